// File: rtl/adc_fifo_sync_ctrl.sv
// adc_fifo_sync_ctrl: single-clock FIFO controller between the ADC sampling
// front end and the FFT loader. The storage is an external non-pipelined LSRAM.
// This block generates the RAM addresses and enables, tracks occupancy, and
// registers the status flags.
//
// Optional build macro: ADC_FIFO_ERR_STICKY_EN
//   - Defined: OVERFLOW/UNDERFLOW are sticky until CLR_ERR or RESET.
//   - Undefined: OVERFLOW/UNDERFLOW are 1-cycle pulses, and CLR_ERR is unused.
//
// Ports:
//   CLOCK, RESET        rising-edge clock; asynchronous active-high reset
//   WE, DATA            write request and write data
//   RE                  read request
//   Q, DVALID           read data (straight from MEM_RD) and its valid strobe
//   FULL, EMPTY         occupancy == DEPTH / occupancy == 0
//   AFULL, AEMPTY       occupancy >= AFULL_TH / occupancy <= AEMPTY_TH
//   WRCNT               occupancy, 0..DEPTH
//   OVERFLOW, UNDERFLOW write rejected while full / read rejected while empty
//   CLR_ERR             clears sticky error flags
//   MEM_*               LSRAM write/read port controls and data
module adc_fifo_sync_ctrl #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned AFULL_TH  = 120,
    parameter int unsigned AEMPTY_TH = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              WE,
    input  logic [WIDTH-1:0]  DATA,
    input  logic              RE,
    output logic [WIDTH-1:0]  Q,
    output logic              DVALID,
    output logic              FULL,
    output logic              EMPTY,
    output logic              AFULL,
    output logic              AEMPTY,
    output logic [ADDR_W:0]   WRCNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    input  logic              CLR_ERR,
    output logic [ADDR_W-1:0] MEM_WADDR,
    output logic              MEM_WE,
    output logic [WIDTH-1:0]  MEM_WD,
    output logic [ADDR_W-1:0] MEM_RADDR,
    output logic              MEM_RE,
    input  logic [WIDTH-1:0]  MEM_RD
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]  wrcnt_q, wrcnt_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              dvalid_q, dvalid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wacc_c;
    logic              racc_c;

    // Acceptance is qualified by last cycle's registered FULL/EMPTY.
    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wacc_c   = WE & ~full_q;
        racc_c   = RE & ~empty_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        if (wacc_c) wptr_d = wptr_q + ADDR_W'(1);
        if (racc_c) rptr_d = rptr_q + ADDR_W'(1);

        wrcnt_d  = wrcnt_q + CNT_W'(wacc_c) - CNT_W'(racc_c);
        full_d   = (wrcnt_d == CNT_W'(DEPTH));
        empty_d  = (wrcnt_d == '0);
        afull_d  = (wrcnt_d >= CNT_W'(AFULL_TH));
        aempty_d = (wrcnt_d <= CNT_W'(AEMPTY_TH));

        // The RAM returns data one cycle after MEM_RE.
        dvalid_d = racc_c;

`ifdef ADC_FIFO_ERR_STICKY_EN
        // A new error wins over CLR_ERR in the same cycle.
        ovf_d    = (WE & full_q)  | (ovf_q & ~CLR_ERR);
        udf_d    = (RE & empty_q) | (udf_q & ~CLR_ERR);
`else
        ovf_d    = WE & full_q;
        udf_d    = RE & empty_q;
`endif
    end

`ifndef ADC_FIFO_ERR_STICKY_EN
    logic unused_clr_err;
    assign unused_clr_err = CLR_ERR;
`endif

    // State registers. An asynchronous reset also kills a DVALID that is
    // already in flight.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            wrcnt_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            wrcnt_q  <= wrcnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign MEM_WE    = wacc_c;
    assign MEM_WADDR = wptr_q;
    assign MEM_WD    = DATA;
    assign MEM_RE    = racc_c;
    assign MEM_RADDR = rptr_q;

    assign Q         = MEM_RD;
    assign DVALID    = dvalid_q;
    assign FULL      = full_q;
    assign EMPTY     = empty_q;
    assign AFULL     = afull_q;
    assign AEMPTY    = aempty_q;
    assign WRCNT     = wrcnt_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = udf_q;

endmodule

// File: tb/tb_adc_fifo_sync_ctrl.sv
// Testbench for adc_fifo_sync_ctrl.
// It contains a behavioural LSRAM, a small occupancy/pointer model, and a data
// scoreboard queue. It also runs a table of short vectors and hand-written
// corner sequences: fill, overflow, drain, wrap, empty write+read, and reset.
module tb_adc_fifo_sync_ctrl;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned ADDR_W = 7;

    logic              CLOCK = 1'b0;
    logic              RESET = 1'b1;
    logic              WE = 1'b0;
    logic              RE = 1'b0;
    logic              CLR_ERR = 1'b0;
    logic [WIDTH-1:0]  DATA = '0;
    logic [WIDTH-1:0]  Q;
    logic              DVALID, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW;
    logic [ADDR_W:0]   WRCNT;
    logic [ADDR_W-1:0] MEM_WADDR, MEM_RADDR;
    logic              MEM_WE, MEM_RE;
    logic [WIDTH-1:0]  MEM_WD;
    logic [WIDTH-1:0]  MEM_RD = '0;

    adc_fifo_sync_ctrl dut (
        .CLOCK(CLOCK), .RESET(RESET), .WE(WE), .DATA(DATA), .RE(RE),
        .Q(Q), .DVALID(DVALID), .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL),
        .AEMPTY(AEMPTY), .WRCNT(WRCNT), .OVERFLOW(OVERFLOW),
        .UNDERFLOW(UNDERFLOW), .CLR_ERR(CLR_ERR), .MEM_WADDR(MEM_WADDR),
        .MEM_WE(MEM_WE), .MEM_WD(MEM_WD), .MEM_RADDR(MEM_RADDR),
        .MEM_RE(MEM_RE), .MEM_RD(MEM_RD)
    );

    always #5 CLOCK = ~CLOCK;

    // Non-pipelined LSRAM: read data is available one cycle after MEM_RE.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge CLOCK) begin
        if (MEM_WE) mem[MEM_WADDR] <= MEM_WD;
        if (MEM_RE) MEM_RD <= mem[MEM_RADDR];
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    int               m_cnt  = 0;
    int               m_wptr = 0;
    int               m_rptr = 0;
    logic             m_dv   = 1'b0;
    logic             m_ovf  = 1'b0;
    logic             m_udf  = 1'b0;
    logic [WIDTH-1:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle.
    // - Drive the inputs at negedge.
    // - Check the combinational RAM controls.
    // - Update the model.
    // - Check the registered outputs just after the following posedge.
    task automatic cycle(input logic we, input logic re, input logic clr, input logic [WIDTH-1:0] d);
        logic wacc, racc, was_full, was_empty;
        logic [WIDTH-1:0] exp_q;
        @(negedge CLOCK);
        WE = we; RE = re; CLR_ERR = clr; DATA = d;
        #1;
        was_full  = (m_cnt == DEPTH);
        was_empty = (m_cnt == 0);
        wacc = we & ~was_full;
        racc = re & ~was_empty;
        chk("mem_we",    32'(MEM_WE),    32'(wacc));
        chk("mem_re",    32'(MEM_RE),    32'(racc));
        chk("mem_waddr", 32'(MEM_WADDR), 32'(m_wptr));
        chk("mem_raddr", 32'(MEM_RADDR), 32'(m_rptr));
        chk("mem_wd",    MEM_WD,         d);
        if (wacc) begin
            sb.push_back(d);
            m_wptr = (m_wptr + 1) % DEPTH;
        end
        if (racc) m_rptr = (m_rptr + 1) % DEPTH;
        m_cnt = m_cnt + int'(wacc) - int'(racc);
        m_dv  = racc;
`ifdef ADC_FIFO_ERR_STICKY_EN
        m_ovf = (we & was_full)  | (m_ovf & ~clr);
        m_udf = (re & was_empty) | (m_udf & ~clr);
`else
        m_ovf = we & was_full;
        m_udf = re & was_empty;
`endif
        @(posedge CLOCK);
        #1;
        chk("wrcnt",     32'(WRCNT),     32'(m_cnt));
        chk("full",      32'(FULL),      32'(m_cnt == DEPTH));
        chk("empty",     32'(EMPTY),     32'(m_cnt == 0));
        chk("afull",     32'(AFULL),     32'(m_cnt >= 120));
        chk("aempty",    32'(AEMPTY),    32'(m_cnt <= 8));
        chk("dvalid",    32'(DVALID),    32'(m_dv));
        chk("overflow",  32'(OVERFLOW),  32'(m_ovf));
        chk("underflow", 32'(UNDERFLOW), 32'(m_udf));
        if (m_dv) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL q_sb: DVALID expected but scoreboard empty at %0t", $time);
            end else begin
                exp_q = sb.pop_front();
                chk("q", Q, exp_q);
            end
        end
    endtask

    typedef struct {
        logic             we;
        logic             re;
        logic [WIDTH-1:0] d;
        int               cnt;
        logic             empty;
        logic             dv;
        logic             udf;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // Hand-derived expectations, starting from an empty FIFO.
        tbl[0] = '{1'b1, 1'b0, 32'hA0, 1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'hA1, 2, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'hA2, 2, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h00, 1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 32'hA3, 1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 32'h00, 0, 1'b1, 1'b0, 1'b0};

        // Check the reset state while RESET is held.
        repeat (2) @(posedge CLOCK);
        #1;
        chk("rst_empty",  32'(EMPTY),  32'd1);
        chk("rst_aempty", 32'(AEMPTY), 32'd1);
        chk("rst_wrcnt",  32'(WRCNT),  32'd0);
        chk("rst_full",   32'(FULL),   32'd0);
        chk("rst_dvalid", 32'(DVALID), 32'd0);
        @(negedge CLOCK);
        RESET = 1'b0;

        // Idle cycles: no RAM activity and the flags stay at reset values.
        repeat (2) cycle(1'b0, 1'b0, 1'b0, '0);

        // Table vectors.
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].we, tbl[i].re, 1'b0, tbl[i].d);
            chk($sformatf("tbl%0d_cnt", i),   32'(WRCNT),  32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_empty", i), 32'(EMPTY),  32'(tbl[i].empty));
            chk($sformatf("tbl%0d_dv", i),    32'(DVALID), 32'(tbl[i].dv));
`ifndef ADC_FIFO_ERR_STICKY_EN
            chk($sformatf("tbl%0d_udf", i),   32'(UNDERFLOW), 32'(tbl[i].udf));
`endif
        end
        cycle(1'b0, 1'b0, 1'b1, '0);

        // Fill all 128 words. AFULL rises after the 120th write and FULL after the 128th.
        for (int i = 0; i < 128; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'(i));
            if (i == 118) chk("afull_before", 32'(AFULL), 32'd0);
            if (i == 119) chk("afull_rise",   32'(AFULL), 32'd1);
            if (i == 126) chk("full_before",  32'(FULL),  32'd0);
        end
        chk("full_rise", 32'(FULL),  32'd1);
        chk("full_cnt",  32'(WRCNT), 32'd128);

        // A write while full is rejected and raises OVERFLOW.
        cycle(1'b1, 1'b0, 1'b0, 32'hDEAD);
        chk("ovf_raise", 32'(OVERFLOW), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Drain all 128 words. Q returns 0..127 through the scoreboard.
        for (int i = 0; i < 128; i++) cycle(1'b0, 1'b1, 1'b0, '0);
        chk("drain_empty", 32'(EMPTY), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b1, '0);

        // Hold occupancy at 5 through 300 simultaneous write+read cycles,
        // wrapping both pointers past 127 to 0.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'(1000 + i));
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 1'b0, 32'(2000 + i));
        chk("steady_cnt", 32'(WRCNT), 32'd5);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, '0);

        // Write and read together on an empty FIFO: the write is accepted,
        // the read is rejected, and no DVALID follows.
        cycle(1'b1, 1'b1, 1'b0, 32'h55);
        chk("ewr_cnt", 32'(WRCNT), 32'd1);
        chk("ewr_dv",  32'(DVALID), 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 32'h56);
        cycle(1'b0, 1'b0, 1'b1, '0);

        // Reset mid-stream while a read is being accepted.
        @(negedge CLOCK);
        WE = 1'b0; RE = 1'b1; CLR_ERR = 1'b0;
        #1;
        chk("pre_rst_re", 32'(MEM_RE), 32'd1);
        RESET = 1'b1;
        #1;
        chk("mid_rst_empty", 32'(EMPTY),  32'd1);
        chk("mid_rst_wrcnt", 32'(WRCNT),  32'd0);
        chk("mid_rst_full",  32'(FULL),   32'd0);
        chk("mid_rst_afl",   32'(AEMPTY), 32'd1);
        chk("mid_rst_mre",   32'(MEM_RE), 32'd0);
        @(posedge CLOCK);
        #1;
        chk("mid_rst_dv",    32'(DVALID), 32'd0);
        chk("mid_rst_ovf",   32'(OVERFLOW) | 32'(UNDERFLOW), 32'd0);
        @(negedge CLOCK);
        RE = 1'b0;
        RESET = 1'b0;
        m_cnt = 0; m_wptr = 0; m_rptr = 0; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        sb.delete();

        // Check the FIFO works normally after the reset.
        cycle(1'b1, 1'b0, 1'b0, 32'hC0FFEE);
        cycle(1'b1, 1'b0, 1'b0, 32'hBEEF);
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_fifo_sync_ctrl.md
Name: adc_fifo_sync_ctrl

Overview:
- Single-clock FIFO controller for the ADC-to-FFT interface.
- Accepts ADC samples from the sampling front end and buffers them in the external LSRAM instance.
- Generates the RAM write/read addresses and enables, and presents read data plus full/empty/almost flags to the FFT loader downstream.
- Sits directly upstream of the RAM wrapper and drives its WADDR/WEN/RADDR/REN ports.

Parameters:
- WIDTH, 32, data width of write data, RAM data and read data.
- DEPTH, 128, number of RAM words; power of two, 4..4096.
- ADDR_W, 7, RAM address width; must equal log2(DEPTH).
- AFULL_TH, 120, AFULL asserts when occupancy >= AFULL_TH.
- AEMPTY_TH, 8, AEMPTY asserts when occupancy <= AEMPTY_TH.

Ports:
- CLOCK  in  1  single system clock; all logic on rising edge.
- RESET  in  1  asynchronous reset, active-high.
- WE  in  1  write request.
- DATA  in  WIDTH  write data.
- RE  in  1  read request.
- Q  out  WIDTH  read data; equals MEM_RD.
- DVALID  out  1  Q valid; asserted the cycle after an accepted read.
- FULL  out  1  occupancy == DEPTH.
- EMPTY  out  1  occupancy == 0.
- AFULL  out  1  almost full.
- AEMPTY  out  1  almost empty.
- WRCNT  out  ADDR_W+1  occupancy, 0..DEPTH.
- OVERFLOW  out  1  write rejected because FIFO was full.
- UNDERFLOW  out  1  read rejected because FIFO was empty.
- CLR_ERR  in  1  clears sticky errors (used only with the optional feature).
- MEM_WADDR  out  ADDR_W  RAM write address.
- MEM_WE  out  1  RAM write enable.
- MEM_WD  out  WIDTH  RAM write data; equals DATA.
- MEM_RADDR  out  ADDR_W  RAM read address.
- MEM_RE  out  1  RAM read enable.
- MEM_RD  in  WIDTH  RAM read data; valid 1 cycle after MEM_RE (non-pipelined LSRAM).

Behaviour:
- Reset values:
  - wptr, rptr, WRCNT = 0.
  - EMPTY = 1, AEMPTY = 1.
  - FULL, AFULL, DVALID, OVERFLOW, UNDERFLOW = 0.
- Write acceptance: wacc = WE & ~FULL.
  - MEM_WE = wacc (combinational); MEM_WADDR = wptr.
  - wptr increments modulo DEPTH on wacc.
- Read acceptance: racc = RE & ~EMPTY.
  - MEM_RE = racc; MEM_RADDR = rptr.
  - rptr increments modulo DEPTH on racc.
- FULL and EMPTY are registered, so acceptance uses the previous cycle's state.
  - Full FIFO with WE & RE: read accepted, write rejected, OVERFLOW raised.
  - Empty FIFO with WE & RE: write accepted, read rejected, UNDERFLOW raised.
  - Neither full nor empty with both accepted: WRCNT unchanged, both pointers advance.
- Occupancy update:
  - WRCNT_next = WRCNT + wacc - racc.
  - All flags are registered from WRCNT_next: FULL = (==DEPTH), EMPTY = (==0), AFULL = (>=AFULL_TH), AEMPTY = (<=AEMPTY_TH).
- Read latency: DVALID is a register of racc, so Q/DVALID appear exactly 1 cycle after the accepted RE.
- Throughput: sustained 1 read/cycle gives back-to-back DVALID.
- Read/write address collision: cannot occur. A read requires occupancy >= 1, so rptr != wptr whenever both enables are active.
- Pointer wrap: DEPTH-1 -> 0 with no gap or extra cycle.
- Errors, default build: OVERFLOW = registered (WE & FULL) and UNDERFLOW = registered (RE & EMPTY), each a 1-cycle pulse. CLR_ERR is ignored.
- Reset mid-operation: all state clears asynchronously and FIFO contents are discarded.
  - A DVALID due in the next cycle is suppressed.
  - RAM contents are not cleared.

Optional Feature:
- Macro ADC_FIFO_ERR_STICKY_EN.
- Defined: OVERFLOW/UNDERFLOW set on the error event and hold until CLR_ERR = 1 or RESET.
  - CLR_ERR and a new error in the same cycle: the flag stays set.
- Undefined: 1-cycle pulses as described in Behaviour; CLR_ERR is unused.

Test Plan:
- Reset, then idle -> EMPTY = 1, AEMPTY = 1, WRCNT = 0, FULL = 0, DVALID = 0, no MEM_WE/MEM_RE.
- Write 128 words 0..127 on consecutive cycles -> MEM_WADDR 0..127; AFULL rises the cycle after the 120th write; FULL and WRCNT = 128 the cycle after the 128th write.
- 129th write while full -> MEM_WE = 0, wptr unchanged, OVERFLOW pulses 1 cycle (sticky build: held until CLR_ERR).
- Read 128 consecutive cycles -> Q = 0..127 in order; each DVALID 1 cycle after its RE; EMPTY after the last read; AEMPTY when WRCNT <= 8.
- Simultaneous WE & RE for 300 cycles at WRCNT = 5 -> WRCNT stays 5, both pointers wrap past 127 to 0, data order preserved.
- WE & RE on an empty FIFO -> write accepted, UNDERFLOW pulses, no DVALID; RESET asserted mid-stream -> all outputs return to reset values immediately.
